uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one 8N1 UART transmitter among NUM_REQ byte sources (echo path, status reporter, debug port, ...) using round-robin arbitration.
- Accepts a byte from the winning requester, issues a single-cycle start strobe to the transmitter, then tracks the transmitter's busy flag until the frame completes.
- Sits between the byte producers and the UART TX serializer, in the same clock domain as the UART RX/TX blocks.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
START_TIMEOUT, 16, max clkIN cycles to wait for txBusyIN to rise after a start strobe (>=2)

Ports:
clkIN  input  1  system clock; one clock, all logic on its rising edge
resetIN  input  1  reset; synchronous, active-high
reqIN  input  NUM_REQ  per-requester byte-valid request, level
dataIN  input  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
ackOUT  output  NUM_REQ  one-cycle pulse: byte from requester i accepted
grantOUT  output  NUM_REQ  one-hot owner of the transmitter; all-zero when idle
txDataOUT  output  8  byte presented to the transmitter
txStartOUT  output  1  one-cycle start strobe to the transmitter
txBusyIN  input  1  transmitter busy; high from after start until stop bit sent
busyOUT  output  1  high whenever state != IDLE
errOUT  output  1  one-cycle pulse: transmitter never went busy (timeout)

Behaviour:
- All outputs registered. Reset (resetIN=1 at a clock edge) forces: state IDLE, ackOUT=0, grantOUT=0, txDataOUT=8'h00, txStartOUT=0, busyOUT=0, errOUT=0, rr pointer=0, timeout counter=0. Reset mid-frame aborts immediately; no start strobe is issued during or after reset until a new request arrives.
- The rr pointer holds the highest-priority index. Search order: ptr, ptr+1, ..., wrap modulo NUM_REQ.
- IDLE: if any reqIN bit is set at edge N, choose the first set index i in search order. At edge N+1: txDataOUT=dataIN[i], grantOUT=one-hot(i), ackOUT[i]=1 for exactly one cycle, busyOUT=1; go to START. If no request, stay in IDLE.
- START: txStartOUT=1 for exactly this one cycle. Clear the timeout counter. Go to WAIT_BUSY.
- WAIT_BUSY: if txBusyIN=1, go to WAIT_DONE. Otherwise increment the counter. When the counter reaches START_TIMEOUT: errOUT=1 for one cycle, grantOUT=0, ptr=i+1 mod NUM_REQ, go to IDLE. The byte is dropped and is not retried.
- WAIT_DONE: when txBusyIN=0, go to IDLE, grantOUT=0, ptr=i+1 mod NUM_REQ. No timeout applies in this state.
- txDataOUT stays stable from the grant until the next grant. txStartOUT is never high outside START.
- Request rules:
  - A requester holds reqIN and its dataIN stable until it sees its ackOUT.
  - If reqIN is still high on the cycle after ack, that is a new byte, arbitrated in the next IDLE cycle.
  - Requests arriving while non-IDLE are held by the requester, not latched by this block.
- Minimum spacing: one IDLE cycle between frames, so the earliest next ackOUT is 1 cycle after the IDLE entry edge.
- Simultaneous requests: exactly one winner per IDLE cycle; ackOUT and grantOUT are always one-hot or zero.
- Fairness: with all NUM_REQ requesting continuously, grants rotate i, i+1, ..., and no requester waits more than NUM_REQ-1 frames.
- A reqIN bit dropped before its ack is legal; that requester is simply not selected.
- txBusyIN already high in START (transmitter stuck busy) is treated like a normal busy: WAIT_BUSY exits on its first cycle.

Test Plan:
- Reset then single request: reqIN=4'b0010, dataIN[15:8]=8'hA5 -> ackOUT=4'b0010 and grantOUT=4'b0010 one cycle later; txDataOUT=8'hA5; txStartOUT high one cycle; busy model 10 cycles -> busyOUT falls and grantOUT=0 on txBusyIN fall.
- All four requesting continuously with bytes 8'h10/8'h11/8'h12/8'h13 -> grant order 0,1,2,3,0 and transmitted bytes 10,11,12,13,10; no ackOUT overlap.
- Requester 3 alone, then requesters 0 and 3 together right after its frame -> ptr=0 after wrap, so requester 0 wins, then 3.
- txBusyIN held 0 after a start, START_TIMEOUT=16 -> errOUT pulses once 16 cycles after the WAIT_BUSY entry; return to IDLE; next requester in order is served.
- resetIN asserted mid-WAIT_DONE with reqIN=4'b1111 -> next cycle all outputs zero; after release, first grant goes to requester 0.
- Held reqIN on requester 2 with dataIN changed on the ack cycle to 8'h5A -> second frame carries 8'h5A; ackOUT pulses exactly twice.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one 8N1 UART transmitter
//
// Purpose:
//    Picks one byte source at a time in round-robin order and hands its byte
//    to the UART TX serializer. It issues a single-cycle start strobe, then
//    follows the transmitter busy flag until the frame is done. If the
//    transmitter never reports busy, the byte is dropped and errOUT pulses.
//
// Ports:
//    clkIN       system clock, rising edge
//    resetIN     synchronous active-high reset
//    reqIN       per-requester byte-valid level
//    dataIN      per-requester byte, requester i on bits [8i+7:8i]
//    ackOUT      one-cycle pulse, byte from requester i accepted
//    grantOUT    one-hot owner of the transmitter, zero when idle
//    txDataOUT   byte presented to the transmitter
//    txStartOUT  one-cycle start strobe to the transmitter
//    txBusyIN    transmitter busy flag
//    busyOUT     high whenever the arbiter is not idle
//    errOUT      one-cycle pulse, transmitter never went busy
module uart_tx_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int START_TIMEOUT = 16
) (
   input  logic                 clkIN,
   input  logic                 resetIN,
   input  logic [NUM_REQ-1:0]   reqIN,
   input  logic [8*NUM_REQ-1:0] dataIN,
   output logic [NUM_REQ-1:0]   ackOUT,
   output logic [NUM_REQ-1:0]   grantOUT,
   output logic [7:0]           txDataOUT,
   output logic                 txStartOUT,
   input  logic                 txBusyIN,
   output logic                 busyOUT,
   output logic                 errOUT
);

   localparam int IDXW = $clog2(NUM_REQ);
   localparam int CNTW = $clog2(START_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} stateT;

   stateT            state, stateNext;
   logic [IDXW-1:0]  ptr, ptrNext;
   logic [IDXW-1:0]  owner, ownerNext;
   logic [CNTW-1:0]  cnt, cntNext;
   logic [NUM_REQ-1:0] ackNext, grantNext;
   logic [7:0]       txDataNext;
   logic             txStartNext, busyNext, errNext;

   logic             winFound;
   logic [IDXW-1:0]  winIdx;
   logic [IDXW-1:0]  probeIdx;
   logic [7:0]       winData;
   logic [NUM_REQ-1:0] winOneHot;
   logic [IDXW-1:0]  ownerInc;
   int               probe;

   // Walk the search order backwards so the entry closest to ptr wins last.
   always_comb begin
      winFound = 1'b0;
      winIdx   = '0;
      probeIdx = '0;
      probe    = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         probe = int'(ptr) + k;
         if (probe >= NUM_REQ) probe = probe - NUM_REQ;
         probeIdx = IDXW'(probe);
         if (reqIN[probeIdx]) begin
            winFound = 1'b1;
            winIdx   = probeIdx;
         end
      end
   end

   always_comb begin
      winData = 8'h00;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winIdx == IDXW'(i)) winData = dataIN[8*i +: 8];
      end
   end

   assign winOneHot = NUM_REQ'(1) << winIdx;
   assign ownerInc  = (owner == IDXW'(NUM_REQ - 1)) ? '0 : owner + IDXW'(1);

   always_comb begin
      stateNext   = state;
      ptrNext     = ptr;
      ownerNext   = owner;
      cntNext     = cnt;
      ackNext     = '0;
      grantNext   = grantOUT;
      txDataNext  = txDataOUT;
      txStartNext = 1'b0;
      errNext     = 1'b0;
      case (state)
         IDLE: begin
            // Strobe is registered together with the START entry so it is
            // high exactly while the state is START.
            if (winFound) begin
               ownerNext   = winIdx;
               ackNext     = winOneHot;
               grantNext   = winOneHot;
               txDataNext  = winData;
               txStartNext = 1'b1;
               stateNext   = START;
            end
         end
         START: begin
            cntNext   = '0;
            stateNext = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (txBusyIN) begin
               stateNext = WAIT_DONE;
            end else if (cnt == CNTW'(START_TIMEOUT - 1)) begin
               // This edge brings the count to START_TIMEOUT: drop the byte.
               errNext   = 1'b1;
               grantNext = '0;
               ptrNext   = ownerInc;
               cntNext   = '0;
               stateNext = IDLE;
            end else begin
               cntNext = cnt + CNTW'(1);
            end
         end
         WAIT_DONE: begin
            if (!txBusyIN) begin
               grantNext = '0;
               ptrNext   = ownerInc;
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
      busyNext = (stateNext != IDLE);
   end

   always_ff @(posedge clkIN) begin
      if (resetIN) begin
         state      <= IDLE;
         ptr        <= '0;
         owner      <= '0;
         cnt        <= '0;
         ackOUT     <= '0;
         grantOUT   <= '0;
         txDataOUT  <= 8'h00;
         txStartOUT <= 1'b0;
         busyOUT    <= 1'b0;
         errOUT     <= 1'b0;
      end else begin
         state      <= stateNext;
         ptr        <= ptrNext;
         owner      <= ownerNext;
         cnt        <= cntNext;
         ackOUT     <= ackNext;
         grantOUT   <= grantNext;
         txDataOUT  <= txDataNext;
         txStartOUT <= txStartNext;
         busyOUT    <= busyNext;
         errOUT     <= errNext;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

   logic        clkIN = 1'b0;
   logic        resetIN = 1'b0;
   logic [3:0]  reqIN = 4'b0000;
   logic [31:0] dataIN = 32'h0;
   logic [3:0]  ackOUT;
   logic [3:0]  grantOUT;
   logic [7:0]  txDataOUT;
   logic        txStartOUT;
   logic        txBusyIN = 1'b0;
   logic        busyOUT;
   logic        errOUT;

   int testCount = 0;
   int failCount = 0;
   int ackTotal  = 0;
   int ackMark   = 0;

   uart_tx_arbiter #(.NUM_REQ(4), .START_TIMEOUT(16)) dut (
      .clkIN      (clkIN),
      .resetIN    (resetIN),
      .reqIN      (reqIN),
      .dataIN     (dataIN),
      .ackOUT     (ackOUT),
      .grantOUT   (grantOUT),
      .txDataOUT  (txDataOUT),
      .txStartOUT (txStartOUT),
      .txBusyIN   (txBusyIN),
      .busyOUT    (busyOUT),
      .errOUT     (errOUT)
   );

   always #5 clkIN = ~clkIN;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clkIN);
      #1;
      if (ackOUT != 4'b0000) ackTotal++;
   endtask

   task automatic checkAllZero(input string tag);
      check({tag, " ack"},   32'(ackOUT),     32'h0);
      check({tag, " grant"}, 32'(grantOUT),   32'h0);
      check({tag, " data"},  32'(txDataOUT),  32'h0);
      check({tag, " start"}, 32'(txStartOUT), 32'h0);
      check({tag, " busy"},  32'(busyOUT),    32'h0);
      check({tag, " err"},   32'(errOUT),     32'h0);
   endtask

   task automatic doReset();
      resetIN = 1'b1;
      step();
      resetIN = 1'b0;
   endtask

   // From START onward: strobe drop, busy for busyLen cycles, return to IDLE.
   task automatic frameRest(input int idx, input int busyLen);
      step();
      check("start drop", 32'(txStartOUT), 32'h0);
      check("ack drop",   32'(ackOUT),     32'h0);
      txBusyIN = 1'b1;
      step();
      repeat (busyLen - 1) step();
      check("grant hold", 32'(grantOUT), 32'(4'b0001 << idx));
      txBusyIN = 1'b0;
      step();
      check("grant clear", 32'(grantOUT), 32'h0);
      check("busy clear",  32'(busyOUT),  32'h0);
   endtask

   task automatic frame(input int idx, input logic [7:0] b, input int busyLen);
      step();
      check("ack",   32'(ackOUT),     32'(4'b0001 << idx));
      check("grant", 32'(grantOUT),   32'(4'b0001 << idx));
      check("data",  32'(txDataOUT),  32'(b));
      check("start", 32'(txStartOUT), 32'h1);
      check("busy",  32'(busyOUT),    32'h1);
      frameRest(idx, busyLen);
   endtask

   initial begin
      // Reset state
      resetIN = 1'b1;
      step();
      step();
      checkAllZero("reset");
      resetIN = 1'b0;

      // Single request from requester 1
      reqIN  = 4'b0010;
      dataIN = 32'h0000_A500;
      step();
      check("single ack",   32'(ackOUT),     32'h2);
      check("single grant", 32'(grantOUT),   32'h2);
      check("single data",  32'(txDataOUT),  32'hA5);
      check("single start", 32'(txStartOUT), 32'h1);
      reqIN = 4'b0000;
      frameRest(1, 10);
      check("single data hold", 32'(txDataOUT), 32'hA5);

      // All four requesting continuously: rotation 0,1,2,3,0
      doReset();
      reqIN  = 4'b1111;
      dataIN = 32'h1312_1110;
      frame(0, 8'h10, 3);
      frame(1, 8'h11, 3);
      frame(2, 8'h12, 3);
      frame(3, 8'h13, 3);
      frame(0, 8'h10, 3);
      reqIN = 4'b0000;

      // Requester 3 alone, then 0 and 3 together: pointer wraps to 0
      dataIN = 32'h3322_1144;
      reqIN  = 4'b1000;
      frame(3, 8'h33, 2);
      reqIN = 4'b1001;
      frame(0, 8'h44, 2);
      frame(3, 8'h33, 2);
      reqIN = 4'b0000;

      // Start timeout: transmitter never goes busy
      reqIN = 4'b0100;
      step();
      check("to ack",   32'(ackOUT),     32'h4);
      check("to start", 32'(txStartOUT), 32'h1);
      reqIN = 4'b0000;
      step();
      check("to start drop", 32'(txStartOUT), 32'h0);
      repeat (15) step();
      check("to err early",  32'(errOUT),   32'h0);
      check("to grant held", 32'(grantOUT), 32'h4);
      check("to busy held",  32'(busyOUT),  32'h1);
      step();
      check("to err",        32'(errOUT),   32'h1);
      check("to grant clr",  32'(grantOUT), 32'h0);
      check("to busy clr",   32'(busyOUT),  32'h0);
      step();
      check("to err pulse",  32'(errOUT),   32'h0);
      reqIN = 4'b1111;
      frame(3, 8'h33, 2);

      // Reset during WAIT_DONE with everyone requesting
      frame(0, 8'h44, 2);
      step();
      check("mid ack", 32'(ackOUT), 32'h2);
      step();
      txBusyIN = 1'b1;
      step();
      step();
      resetIN = 1'b1;
      step();
      checkAllZero("mid reset");
      step();
      check("mid reset start", 32'(txStartOUT), 32'h0);
      resetIN  = 1'b0;
      txBusyIN = 1'b0;
      frame(0, 8'h44, 2);
      reqIN = 4'b0000;

      // Held request on requester 2, byte changed on the ack cycle
      dataIN  = 32'h0077_0000;
      reqIN   = 4'b0100;
      ackMark = ackTotal;
      step();
      check("held ack1",  32'(ackOUT),    32'h4);
      check("held data1", 32'(txDataOUT), 32'h77);
      dataIN[23:16] = 8'h5A;
      frameRest(2, 4);
      step();
      check("held ack2",  32'(ackOUT),    32'h4);
      check("held data2", 32'(txDataOUT), 32'h5A);
      reqIN = 4'b0000;
      frameRest(2, 4);
      repeat (3) step();
      check("held ack count", 32'(ackTotal - ackMark), 32'd2);
      check("idle busy",      32'(busyOUT),            32'h0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
